fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter PC_W, default 32: PC, address and instruction width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 stall  in  1  ID hazard: hold IF/ID payload, do not advance PC.
REQ-006 br_taken  in  1  one-cycle pulse from ID: redirect fetch.
REQ-007 br_pc  in  PC_W  PC of the branch instruction in ID.
REQ-008 br_offset  in  PC_W  signed word offset of the branch.
REQ-009 imem_req  out  1  instruction-memory read request.
REQ-010 imem_addr  out  PC_W  read address, always equal to pc.
REQ-011 imem_ready  in  1  read data valid this cycle.
REQ-012 imem_data  in  PC_W  instruction word.
REQ-013 if_valid  out  1  IF/ID payload valid.
REQ-014 if_pc  out  PC_W  PC of payload instruction.
REQ-015 if_inst  out  PC_W  payload instruction.
REQ-016 if_flush  out  1  one-cycle pulse: IF/ID payload squashed.

Function
REQ-017 States: START, FETCH, HOLD; encoded in a 2-bit enum.
REQ-018 START: imem_req=0; next cycle FETCH.
REQ-019 FETCH: imem_req=1; on imem_ready & !stall, register if_inst=imem_data, if_pc=pc, if_valid=1, pc<=pc+4, remain FETCH.
REQ-020 FETCH, imem_ready & stall: capture word and pc in skid buffer, payload unchanged, pc held, go HOLD.
REQ-021 FETCH, !imem_ready: no PC change; if !stall, if_valid<=0 next cycle; if stall, payload held.
REQ-022 HOLD: imem_req=0; when stall drops, skid word loaded to payload with if_valid=1, pc<=pc+4, go FETCH (single-cycle handoff, no bubble).
REQ-023 stall high: if_valid, if_pc, if_inst held unchanged every cycle.
REQ-024 br_target = br_pc + 4 + (br_offset << 2), modulo 2^PC_W, wrap silent.
REQ-025 br_taken has priority over stall and imem_ready: pc<=br_target, skid buffer and payload invalidated (if_valid<=0), if_flush=1 for that one cycle, go FETCH.
REQ-026 An abandoned in-flight request is legal; the memory tolerates an address change without ready.
REQ-027 PC increment wraps from 2^PC_W-4 to 0 without error.
REQ-028 br_taken is ignored in START.

Reset
REQ-029 rst=0 at a clock edge: pc=RESET_PC, state=START, if_valid=0, if_pc=0, if_inst=0, if_flush=0, skid invalid; applies mid-transaction, any state.

Configuration
REQ-030 Macro FETCH_DELAY_SLOT_EN: when defined, on br_taken the word with PC br_pc+4 (in skid buffer or returning that cycle) is delivered as a valid payload, not squashed, and if_flush is not asserted for it; pc still redirects to br_target.
REQ-031 Without FETCH_DELAY_SLOT_EN: all words fetched after the branch are squashed per REQ-025.

Structure
REQ-032 Shared package fetch_pkg: state enum, PC_INC=4, RESET_PC default.
REQ-033 One sub-module fetch_skid_buf (one-entry word+pc buffer with valid bit); target adder inline.

Verification
REQ-034 Reset then imem_ready=1 constant: imem_addr 0,4,8,12 in consecutive cycles; if_pc lags by one cycle.
REQ-035 stall high 3 cycles with ready: if_pc frozen (e.g. 8), pc frozen at 12; on release if_pc=12 next cycle, no bubble.
REQ-036 br_taken, br_pc=16, br_offset=3: next imem_addr=32, if_flush=1 one cycle, if_valid=0 next cycle.
REQ-037 br_taken and stall same cycle in HOLD: redirect taken, skid discarded; with FETCH_DELAY_SLOT_EN, word at br_pc+4 appears as if_valid=1.
REQ-038 imem_ready low 2 cycles: imem_addr held, if_valid=0 those cycles; rst=0 mid-wait yields imem_addr=RESET_PC two cycles later.
REQ-039 pc=32'hFFFF_FFFC fetched: next imem_addr=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction-fetch controller files.
//   fetch_state_t    : controller state (START, FETCH, HOLD) in a 2-bit enum
//   PC_INC           : byte increment between sequential instruction words
//   RESET_PC_DEFAULT : default PC loaded on reset
package fetch_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int          PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory read bus between the fetch controller and
// the instruction memory.
//   imem_req   : read request (controller -> memory)
//   imem_addr  : read address (controller -> memory)
//   imem_ready : read data valid this cycle (memory -> controller)
//   imem_data  : instruction word (memory -> controller)
// Modports: master = fetch controller, slave = instruction memory.
interface fetch_ctrl_if #(
  parameter int PC_W = 32
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [PC_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry buffer holding an instruction word and its PC
// while the decode stage is stalled.
//   clk, rst  : clock, synchronous active-low reset
//   load      : capture load_word/load_pc and mark the entry valid
//   clear     : invalidate the entry (wins over load)
//   load_word : instruction word to capture
//   load_pc   : PC of that word
//   valid     : entry holds a word
//   word, pc  : buffered word and its PC
module fetch_skid_buf #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [PC_W-1:0] load_word,
  input  logic [PC_W-1:0] load_pc,
  output logic            valid,
  output logic [PC_W-1:0] word,
  output logic [PC_W-1:0] pc
);

  // A clear squashes any pending load so a redirect never leaves a stale
  // word behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      word  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= load_word;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller feeding the IF/ID payload register.
// Fetches sequentially from instruction memory, parks a returning word in a
// one-entry skid buffer while decode stalls, and redirects on taken branches.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   stall      : decode hazard, hold payload and PC
//   br_taken   : one-cycle redirect pulse from decode
//   br_pc      : PC of the branch in decode
//   br_offset  : signed word offset of the branch
//   imem       : instruction-memory bus (fetch_ctrl_if.master)
//   if_valid   : payload valid
//   if_pc      : payload PC
//   if_inst    : payload instruction
//   if_flush   : one-cycle pulse, payload squashed by a branch
// Build option: FETCH_DELAY_SLOT_EN keeps the word at br_pc+4 (the branch
// delay slot) as a valid payload instead of squashing it.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int            PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [PC_W-1:0]   br_offset,
  fetch_ctrl_if.master      imem,
  output logic              if_valid,
  output logic [PC_W-1:0]   if_pc,
  output logic [PC_W-1:0]   if_inst,
  output logic              if_flush
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next_seq;
  logic [PC_W-1:0] br_target;
  logic            redirect;
  logic            skid_load;
  logic            skid_clear;
  logic            skid_valid;
  logic [PC_W-1:0] skid_word;
  logic [PC_W-1:0] skid_pc;

  // Memory is only asked for a word while no word is parked in the skid.
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;

  assign pc_next_seq = pc + PC_W'(PC_INC);
  assign br_target   = br_pc + PC_W'(PC_INC) + (br_offset << 2);

  // A branch in START has no fetch to redirect, so it is ignored there.
  assign redirect = br_taken && (state != START);

  assign skid_load  = (state == FETCH) && !br_taken && imem.imem_ready && stall;
  assign skid_clear = redirect || ((state == HOLD) && !stall);

`ifdef FETCH_DELAY_SLOT_EN
  // The delay-slot word is either parked in the skid or returning right now.
  logic            ds_from_skid;
  logic            ds_from_mem;
  logic [PC_W-1:0] ds_slot_pc;

  assign ds_slot_pc   = br_pc + PC_W'(PC_INC);
  assign ds_from_skid = (state == HOLD) && skid_valid && (skid_pc == ds_slot_pc);
  assign ds_from_mem  = (state == FETCH) && imem.imem_ready && (pc == ds_slot_pc);
`endif

  fetch_skid_buf #(
    .PC_W (PC_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_word (imem.imem_data),
    .load_pc   (pc),
    .valid     (skid_valid),
    .word      (skid_word),
    .pc        (skid_pc)
  );

  // Controller FSM with registered payload outputs. A redirect outranks
  // stall and ready; HOLD releases its parked word in the same cycle the
  // stall drops so no bubble appears.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= START;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
      if_flush <= 1'b0;
    end else begin
      if_flush <= 1'b0;
      case (state)
        START: begin
          state <= FETCH;
        end
        FETCH, HOLD: begin
          if (redirect) begin
            pc    <= br_target;
            state <= FETCH;
`ifdef FETCH_DELAY_SLOT_EN
            if (ds_from_skid) begin
              if_valid <= 1'b1;
              if_pc    <= skid_pc;
              if_inst  <= skid_word;
            end else if (ds_from_mem) begin
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_inst  <= imem.imem_data;
            end else begin
              if_valid <= 1'b0;
              if_flush <= 1'b1;
            end
`else
            if_valid <= 1'b0;
            if_flush <= 1'b1;
`endif
          end else if (state == HOLD) begin
            if (!stall && skid_valid) begin
              if_valid <= 1'b1;
              if_pc    <= skid_pc;
              if_inst  <= skid_word;
              pc       <= pc_next_seq;
              state    <= FETCH;
            end
          end else if (imem.imem_ready) begin
            if (stall) begin
              state <= HOLD;
            end else begin
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_inst  <= imem.imem_data;
              pc       <= pc_next_seq;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        default: begin
          state <= START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. A behavioural model of
// the fetch rules predicts every output each cycle; literal expectations pin
// the key scenarios (sequential fetch, stall/skid, branch, wait, wrap, reset).
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = 32'h0;
  logic [31:0] br_offset = 32'h0;
  logic        ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_flush;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: "held" is a word waiting for decode to accept it.
  bit          m_started = 1'b0;
  logic [31:0] m_pc = 32'h0;
  bit          m_held = 1'b0;
  logic [31:0] m_held_pc = 32'h0;
  logic [31:0] m_held_word = 32'h0;
  bit          m_vld = 1'b0;
  logic [31:0] m_ppc = 32'h0;
  logic [31:0] m_pinst = 32'h0;
  bit          m_flush = 1'b0;

  fetch_ctrl_if #(.PC_W(32)) bus ();

  fetch_ctrl #(
    .PC_W     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .imem      (bus.master),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_flush  (if_flush)
  );

  always #5 clk = ~clk;

  // Instruction memory: every address holds a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign bus.imem_ready = ready;
  assign bus.imem_data  = mem_word(bus.imem_addr);

  task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    logic [31:0] word_now;
    word_now = mem_word(m_pc);
    m_flush  = 1'b0;
    if (!rst) begin
      m_started = 1'b0;
      m_pc      = 32'h0;
      m_held    = 1'b0;
      m_vld     = 1'b0;
      m_ppc     = 32'h0;
      m_pinst   = 32'h0;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (br_taken) begin
`ifdef FETCH_DELAY_SLOT_EN
      if (m_held && m_held_pc == br_pc + 32'd4) begin
        m_vld = 1'b1; m_ppc = m_held_pc; m_pinst = m_held_word;
      end else if (!m_held && ready && m_pc == br_pc + 32'd4) begin
        m_vld = 1'b1; m_ppc = m_pc; m_pinst = word_now;
      end else begin
        m_vld = 1'b0; m_flush = 1'b1;
      end
`else
      m_vld   = 1'b0;
      m_flush = 1'b1;
`endif
      m_held = 1'b0;
      m_pc   = br_pc + 32'd4 + br_offset * 32'd4;
    end else if (m_held) begin
      if (!stall) begin
        m_vld   = 1'b1;
        m_ppc   = m_held_pc;
        m_pinst = m_held_word;
        m_held  = 1'b0;
        m_pc    = m_pc + 32'd4;
      end
    end else if (ready) begin
      if (stall) begin
        m_held      = 1'b1;
        m_held_pc   = m_pc;
        m_held_word = word_now;
      end else begin
        m_vld   = 1'b1;
        m_ppc   = m_pc;
        m_pinst = word_now;
        m_pc    = m_pc + 32'd4;
      end
    end else if (!stall) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic checkOutput();
    checkLit("imem_req",  {31'b0, bus.imem_req}, {31'b0, (m_started && !m_held)});
    checkLit("imem_addr", bus.imem_addr, m_pc);
    checkLit("if_valid",  {31'b0, if_valid}, {31'b0, m_vld});
    checkLit("if_flush",  {31'b0, if_flush}, {31'b0, m_flush});
    if (m_vld) begin
      checkLit("if_pc",   if_pc, m_ppc);
      checkLit("if_inst", if_inst, m_pinst);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic b,
                               input logic [31:0] bpc, input logic [31:0] boff,
                               input logic rdy);
    rst       = r;
    stall     = s;
    br_taken  = b;
    br_pc     = bpc;
    br_offset = boff;
    ready     = rdy;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] pat_stall;
    logic [15:0] pat_ready;
    pat_stall = 16'b0110_0010_1100_0100;
    pat_ready = 16'b1011_1101_0110_1111;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkLit("rst_req",   {31'b0, bus.imem_req}, 32'd0);
    checkLit("rst_addr",  bus.imem_addr, 32'h0);
    checkLit("rst_valid", {31'b0, if_valid}, 32'd0);
    checkLit("rst_if_pc", if_pc, 32'h0);
    checkLit("rst_inst",  if_inst, 32'h0);
    checkLit("rst_flush", {31'b0, if_flush}, 32'd0);

    // Sequential fetch with ready held high
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkLit("seq_addr0", bus.imem_addr, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkLit("seq_addr4", bus.imem_addr, 32'd4);
    checkLit("seq_pc0",   if_pc, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkLit("seq_addr8", bus.imem_addr, 32'd8);
    checkLit("seq_pc4",   if_pc, 32'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkLit("seq_addr12", bus.imem_addr, 32'd12);
    checkLit("seq_pc8",    if_pc, 32'd8);

    // Stall three cycles, then release with no bubble
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
      checkLit("stall_if_pc", if_pc, 32'd8);
      checkLit("stall_addr",  bus.imem_addr, 32'd12);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkLit("release_if_pc", if_pc, 32'd12);
    checkLit("release_valid", {31'b0, if_valid}, 32'd1);
    checkLit("release_addr",  bus.imem_addr, 32'd16);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Branch from 16 with offset 3 -> 32
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd16, 32'd3, 1'b1);
    checkLit("br_addr",  bus.imem_addr, 32'd32);
    checkLit("br_flush", {31'b0, if_flush}, 32'd1);
    checkLit("br_valid", {31'b0, if_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkLit("br_flush_end", {31'b0, if_flush}, 32'd0);
    checkLit("br_first_pc",  if_pc, 32'd32);

    // Memory not ready for two cycles
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkLit("wait_addr",  bus.imem_addr, 32'd36);
      checkLit("wait_valid", {31'b0, if_valid}, 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkLit("wait_done_pc", if_pc, 32'd36);

    // Branch while parked in HOLD with stall still high: skid discarded
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd36, 32'd5, 1'b1);
    checkLit("hold_br_addr", bus.imem_addr, 32'd60);
`ifdef FETCH_DELAY_SLOT_EN
    checkLit("hold_br_ds_valid", {31'b0, if_valid}, 32'd1);
    checkLit("hold_br_ds_pc",    if_pc, 32'd40);
`else
    checkLit("hold_br_valid", {31'b0, if_valid}, 32'd0);
    checkLit("hold_br_flush", {31'b0, if_flush}, 32'd1);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkLit("hold_br_next_pc", if_pc, 32'd60);

    // PC wrap: branch to 0xFFFF_FFFC, then increment to 0
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFE, 1'b1);
    checkLit("wrap_target", bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checkLit("wrap_addr0", bus.imem_addr, 32'h0);
    checkLit("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Reset in the middle of a memory wait
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkLit("midrst_addr",  bus.imem_addr, 32'h0);
    checkLit("midrst_valid", {31'b0, if_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkLit("midrst_addr2", bus.imem_addr, 32'h0);
    checkLit("midrst_req",   {31'b0, bus.imem_req}, 32'd1);

    // Branch during START is ignored
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd100, 32'd1, 1'b1);
    checkLit("start_br_addr",  bus.imem_addr, 32'h0);
    checkLit("start_br_flush", {31'b0, if_flush}, 32'd0);

    // Stall while memory is not ready: payload held valid
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    checkLit("stall_wait_valid", {31'b0, if_valid}, 32'd1);
    checkLit("stall_wait_pc",    if_pc, 32'd0);
    checkLit("stall_wait_addr",  bus.imem_addr, 32'd4);

    // Mixed stall/ready pattern checked against the model only
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, pat_stall[i], 1'b0, 32'h0, 32'h0, pat_ready[i]);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
